diff_rank_selector: RTL

DIFF_RANK_SELECTOR -- requirements
Module: diff_rank_selector

---
 rtl/diff_rank_selector.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/diff_rank_selector.sv
// Scans NUM_ENTRIES DIFF values from a synchronous-read memory and reports the
// smallest and runner-up entries, plus whether the gap between them is confident.
module diff_rank_selector #(
    parameter int unsigned NUM_ENTRIES = 26,
    parameter logic [14:0] MARGIN      = 15'd8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [14:0] MEM_DATA,
    output logic [5:0]  MEM_ADDR,
    output logic        MEM_CS,
    output logic        MEM_RW_,
    output logic        BUSY,
    output logic        OE,
    output logic [5:0]  BEST_ADDR,
    output logic [14:0] BEST_DIFF,
    output logic [5:0]  SECOND_ADDR,
    output logic [14:0] SECOND_DIFF,
    output logic        CONFIDENT
);

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 15;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_ENTRIES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_addr, w_addr_nxt;
    logic          r_cs, w_cs_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_oe, w_oe_nxt;
    logic          w_scan_start;

    // Read-return tag: which address the current MEM_DATA belongs to
    logic          r_rd_vld;
    logic [AW-1:0] r_rd_addr;

    logic [AW-1:0] r_best_addr, r_sec_addr, w_best_addr, w_sec_addr;
    logic [DW-1:0] r_best_diff, r_sec_diff, w_best_diff, w_sec_diff;
    logic [DW-1:0] w_gap;

    logic [AW-1:0] r_o_best_addr, r_o_sec_addr;
    logic [DW-1:0] r_o_best_diff, r_o_sec_diff;
    logic          r_o_conf;

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = '0;
        w_cs_nxt     = 1'b0;
        w_busy_nxt   = 1'b0;
        w_oe_nxt     = 1'b0;
        w_scan_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_state_nxt  = S_READ;
                    w_cs_nxt     = 1'b1;
                    w_busy_nxt   = 1'b1;
                    w_scan_start = 1'b1;
                end
            end
            S_READ: begin
                w_busy_nxt = 1'b1;
                if (r_addr == LAST_ADDR) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_addr_nxt = r_addr + AW'(1);
                    w_cs_nxt   = 1'b1;
                end
            end
            S_DRAIN: begin
                w_state_nxt = S_DONE;
                w_oe_nxt    = 1'b1;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Insert the returning datum into the working best/second pair
    always_comb begin
        w_best_addr = r_best_addr;
        w_best_diff = r_best_diff;
        w_sec_addr  = r_sec_addr;
        w_sec_diff  = r_sec_diff;
        if (r_rd_vld) begin
            if (r_rd_addr == '0) begin
                w_best_addr = r_rd_addr;
                w_best_diff = MEM_DATA;
            end else if (MEM_DATA < r_best_diff) begin
                w_sec_addr  = r_best_addr;
                w_sec_diff  = r_best_diff;
                w_best_addr = r_rd_addr;
                w_best_diff = MEM_DATA;
            end else if ((r_rd_addr == AW'(1)) || (MEM_DATA < r_sec_diff)) begin
                w_sec_addr = r_rd_addr;
                w_sec_diff = MEM_DATA;
            end
        end
        w_gap = w_sec_diff - w_best_diff;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_cs          <= 1'b0;
            r_busy        <= 1'b0;
            r_oe          <= 1'b0;
            r_rd_vld      <= 1'b0;
            r_rd_addr     <= '0;
            r_best_addr   <= '0;
            r_best_diff   <= '0;
            r_sec_addr    <= '0;
            r_sec_diff    <= '0;
            r_o_best_addr <= '0;
            r_o_best_diff <= '0;
            r_o_sec_addr  <= '0;
            r_o_sec_diff  <= '0;
            r_o_conf      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_cs      <= w_cs_nxt;
            r_busy    <= w_busy_nxt;
            r_oe      <= w_oe_nxt;
            r_rd_vld  <= (r_state == S_READ);
            r_rd_addr <= r_addr;
            if (w_scan_start) begin
                r_best_addr <= '0;
                r_best_diff <= '0;
                r_sec_addr  <= '0;
                r_sec_diff  <= '0;
            end else begin
                r_best_addr <= w_best_addr;
                r_best_diff <= w_best_diff;
                r_sec_addr  <= w_sec_addr;
                r_sec_diff  <= w_sec_diff;
            end
            // The last datum arrives in DRAIN, so results latch on the edge into DONE
            if (w_oe_nxt) begin
                r_o_best_addr <= w_best_addr;
                r_o_best_diff <= w_best_diff;
                r_o_sec_addr  <= w_sec_addr;
                r_o_sec_diff  <= w_sec_diff;
                r_o_conf      <= (w_gap >= MARGIN);
            end
        end
    end

    assign MEM_ADDR    = r_addr;
    assign MEM_CS      = r_cs;
    assign MEM_RW_     = 1'b1;
    assign BUSY        = r_busy;
    assign OE          = r_oe;
    assign BEST_ADDR   = r_o_best_addr;
    assign BEST_DIFF   = r_o_best_diff;
    assign SECOND_ADDR = r_o_sec_addr;
    assign SECOND_DIFF = r_o_sec_diff;
    assign CONFIDENT   = r_o_conf;

endmodule
